// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode encodings, instruction-register field
// positions and the instruction-fetch state encoding.
package sisc_pkg;

   localparam logic [3:0] OP_NOOP = 4'd0;
   localparam logic [3:0] OP_BRA  = 4'd4;
   localparam logic [3:0] OP_BRR  = 4'd5;
   localparam logic [3:0] OP_BNE  = 4'd6;
   localparam logic [3:0] OP_BNR  = 4'd7;
   localparam logic [3:0] OP_HLT  = 4'd15;

   // Field MSB positions within the 32-bit instruction word
   localparam int FIELD_W = 4;
   localparam int IMM_W   = 16;
   localparam int OPC_MSB = 31;
   localparam int MM_MSB  = 27;
   localparam int RD_MSB  = 23;
   localparam int RS_MSB  = 19;
   localparam int RT_MSB  = 15;
   localparam int IMM_MSB = 15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
interface ifetch_unit_if #(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 32
) ();

   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_data
   );

endinterface

// File: rtl/branch_target.sv
// Combinational branch decision: whether the current IR branch is taken and
// where it goes. Relative targets are based on the already-incremented pc.
module branch_target
   import sisc_pkg::*;
#(
   parameter int PC_W = 16
) (
   input  logic [3:0]      opcode,
   input  logic [3:0]      mm,
   input  logic [3:0]      stat,
   input  logic [PC_W-1:0] pc,
   input  logic [15:0]     imm,
   output logic            take,
   output logic [PC_W-1:0] target
);

   logic            cond;
   logic [PC_W-1:0] imm_abs;
   logic [PC_W-1:0] imm_rel;

   generate
      if (PC_W <= IMM_W) begin : g_narrow
         assign imm_abs = imm[PC_W-1:0];
         assign imm_rel = imm[PC_W-1:0];
      end else begin : g_wide
         assign imm_abs = {{(PC_W-IMM_W){1'b0}}, imm};
         assign imm_rel = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
      end
   endgenerate

   assign cond = |(stat & mm);

   always_comb begin
      take   = 1'b0;
      target = pc;
      case (opcode)
         OP_BRA: begin
            take   = cond || (mm == 4'd0);
            target = imm_abs;
         end
         OP_BRR: begin
            take   = cond || (mm == 4'd0);
            target = pc + imm_rel;
         end
         OP_BNE: begin
            take   = !cond;
            target = imm_abs;
         end
         OP_BNR: begin
            take   = !cond;
            target = pc + imm_rel;
         end
         default: begin
            take   = 1'b0;
            target = pc;
         end
      endcase
   end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch responder: owns pc and IR, reads instruction memory on
// request, decodes IR fields and applies branch pc updates while idle.
module ifetch_unit
   import sisc_pkg::*;
#(
   parameter int PC_W    = 16,
   parameter int INSTR_W = 32,
   parameter int TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst_f,
   ifetch_unit_if.master   imem,
   input  logic            fetch_req,
   input  logic            br_req,
   input  logic [3:0]      stat,
   output logic [3:0]      opcode,
   output logic [3:0]      mm,
   output logic [3:0]      rd,
   output logic [3:0]      rs,
   output logic [3:0]      rt,
   output logic [15:0]     imm,
   output logic [PC_W-1:0] pc,
   output logic            ir_valid,
   output logic            busy,
   output logic            halted,
   output logic            fetch_err
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

   fetch_state_e        state_reg, state_next;
   logic [PC_W-1:0]     pc_reg, pc_next;
   logic [INSTR_W-1:0]  ir_reg, ir_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic                halted_reg, halted_next;
   logic                err_reg, err_next;

   logic                br_take;
   logic [PC_W-1:0]     br_target;

   branch_target #(
      .PC_W (PC_W)
   ) u_branch_target (
      .opcode (opcode),
      .mm     (mm),
      .stat   (stat),
      .pc     (pc_reg),
      .imm    (imm),
      .take   (br_take),
      .target (br_target)
   );

   always_ff @(posedge clk) begin
      if (rst_f) begin
         state_reg  <= IDLE;
         pc_reg     <= '0;
         ir_reg     <= '0;
         cnt_reg    <= '0;
         halted_reg <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         ir_reg     <= ir_next;
         cnt_reg    <= cnt_next;
         halted_reg <= halted_next;
         err_reg    <= err_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      ir_next     = ir_reg;
      cnt_next    = cnt_reg;
      halted_next = halted_reg;
      err_next    = 1'b0;
      case (state_reg)
         IDLE: begin
            // A branch and a fetch in the same cycle: the fetch reads the target
            if (br_req && br_take) begin
               pc_next = br_target;
            end
            if (fetch_req && !halted_reg) begin
               state_next = REQ;
               cnt_next   = '0;
            end
         end
         REQ: begin
            if (imem.imem_ack) begin
               ir_next    = imem.imem_data;
               pc_next    = pc_reg + PC_W'(1);
               state_next = DONE;
               if (imem.imem_data[OPC_MSB -: FIELD_W] == OP_HLT) begin
                  halted_next = 1'b1;
               end
            end else if (cnt_reg == CNT_LAST) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign imem.imem_req  = (state_reg == REQ);
   assign imem.imem_addr = pc_reg;

   assign opcode    = ir_reg[OPC_MSB -: FIELD_W];
   assign mm        = ir_reg[MM_MSB  -: FIELD_W];
   assign rd        = ir_reg[RD_MSB  -: FIELD_W];
   assign rs        = ir_reg[RS_MSB  -: FIELD_W];
   assign rt        = ir_reg[RT_MSB  -: FIELD_W];
   assign imm       = ir_reg[IMM_MSB -: IMM_W];
   assign pc        = pc_reg;
   assign ir_valid  = (state_reg == DONE);
   assign busy      = (state_reg != IDLE);
   assign halted    = halted_reg;
   assign fetch_err = err_reg;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit: fetch latency, ack waits,
// timeout, branch rules, pc wrap, halt and mid-fetch reset.
module tb_ifetch_unit;

   localparam int PC_W    = 16;
   localparam int INSTR_W = 32;

   logic            clk;
   logic            rst_f;
   logic            fetch_req;
   logic            br_req;
   logic [3:0]      stat;
   logic [3:0]      opcode, mm, rd, rs, rt;
   logic [15:0]     imm;
   logic [PC_W-1:0] pc;
   logic            ir_valid, busy, halted, fetch_err;

   int ntests;
   int nfail;

   ifetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

   ifetch_unit #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W),
      .TIMEOUT (15)
   ) dut (
      .clk       (clk),
      .rst_f     (rst_f),
      .imem      (bus.master),
      .fetch_req (fetch_req),
      .br_req    (br_req),
      .stat      (stat),
      .opcode    (opcode),
      .mm        (mm),
      .rd        (rd),
      .rs        (rs),
      .rt        (rt),
      .imm       (imm),
      .pc        (pc),
      .ir_valid  (ir_valid),
      .busy      (busy),
      .halted    (halted),
      .fetch_err (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Zero-wait fetch; returns in IDLE one cycle after the ir_valid pulse.
   task automatic fetch_now(input logic [31:0] data);
      $display("[TB] fetch addr=0x%04h data=0x%08h", pc, data);
      fetch_req = 1'b1;
      tick();
      fetch_req     = 1'b0;
      bus.imem_ack  = 1'b1;
      bus.imem_data = data;
      tick();
      bus.imem_ack = 1'b0;
      chk("fetch_ir_valid", 32'(ir_valid), 32'd1);
      tick();
   endtask

   task automatic branch(input logic [3:0] s, input logic [15:0] exp_pc);
      stat   = s;
      br_req = 1'b1;
      tick();
      br_req = 1'b0;
      $display("[TB] branch op=%0d mm=0x%0h stat=0x%0h -> pc=0x%04h", opcode, mm, s, pc);
      chk("branch_pc", 32'(pc), 32'(exp_pc));
   endtask

   initial begin
      ntests        = 0;
      nfail         = 0;
      rst_f         = 1'b1;
      fetch_req     = 1'b0;
      br_req        = 1'b0;
      stat          = 4'd0;
      bus.imem_ack  = 1'b0;
      bus.imem_data = '0;
      tick();
      tick();
      rst_f = 1'b0;

      // Reset state
      chk("rst_pc",       32'(pc),           32'd0);
      chk("rst_opcode",   32'(opcode),       32'd0);
      chk("rst_imm",      32'(imm),          32'd0);
      chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
      chk("rst_busy",     32'(busy),         32'd0);
      chk("rst_halted",   32'(halted),       32'd0);
      chk("rst_valid",    32'(ir_valid),     32'd0);
      chk("rst_err",      32'(fetch_err),    32'd0);

      // Zero-wait fetch of 0x1012_0034
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      chk("t1_req",   32'(bus.imem_req),  32'd1);
      chk("t1_addr",  32'(bus.imem_addr), 32'd0);
      chk("t1_novld", 32'(ir_valid),      32'd0);
      bus.imem_ack  = 1'b1;
      bus.imem_data = 32'h1012_0034;
      tick();
      bus.imem_ack = 1'b0;
      $display("[TB] fetch 0x10120034 opcode=%0d rd=%0d rs=%0d imm=0x%04h pc=0x%04h", opcode, rd, rs, imm, pc);
      chk("t1_valid",  32'(ir_valid), 32'd1);
      chk("t1_opcode", 32'(opcode),   32'd1);
      chk("t1_mm",     32'(mm),       32'd0);
      chk("t1_rd",     32'(rd),       32'd1);
      chk("t1_rs",     32'(rs),       32'd2);
      chk("t1_imm",    32'(imm),      32'h0034);
      chk("t1_pc",     32'(pc),       32'd1);
      chk("t1_busy",   32'(busy),     32'd1);
      tick();
      chk("t1_pulse", 32'(ir_valid), 32'd0);
      chk("t1_idle",  32'(busy),     32'd0);

      // Ack delayed by 5 wait cycles
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("t2_req_hold", 32'(bus.imem_req),  32'd1);
         chk("t2_addr",     32'(bus.imem_addr), 32'd1);
         chk("t2_novld",    32'(ir_valid),      32'd0);
         tick();
      end
      chk("t2_req_last", 32'(bus.imem_req), 32'd1);
      bus.imem_ack  = 1'b1;
      bus.imem_data = 32'h2034_5678;
      tick();
      bus.imem_ack = 1'b0;
      $display("[TB] delayed fetch 0x20345678 pc=0x%04h valid=%0b", pc, ir_valid);
      chk("t2_valid", 32'(ir_valid), 32'd1);
      chk("t2_pc",    32'(pc),       32'd2);
      chk("t2_rd",    32'(rd),       32'd3);
      chk("t2_rt",    32'(rt),       32'd5);
      chk("t2_imm",   32'(imm),      32'h5678);
      tick();
      chk("t2_pulse", 32'(ir_valid), 32'd0);

      // Timeout: 16 unacked request cycles
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("t3_req_hold", 32'(bus.imem_req), 32'd1);
         chk("t3_no_err",   32'(fetch_err),    32'd0);
         tick();
      end
      $display("[TB] timeout fetch_err=%0b pc=0x%04h busy=%0b", fetch_err, pc, busy);
      chk("t3_err",    32'(fetch_err),    32'd1);
      chk("t3_pc",     32'(pc),           32'd2);
      chk("t3_busy",   32'(busy),         32'd0);
      chk("t3_req",    32'(bus.imem_req), 32'd0);
      chk("t3_ir",     32'(opcode),       32'd2);
      tick();
      chk("t3_pulse", 32'(fetch_err), 32'd0);

      // Following fetch succeeds: BRA mm=0 imm=0x000F
      fetch_now(32'h4000_000F);
      chk("t4_pc",     32'(pc),     32'd3);
      chk("t4_opcode", 32'(opcode), 32'd4);
      branch(4'h0, 16'h000F);

      // BRR mm=1 imm=-2 from pc 0x0010
      fetch_now(32'h5100_FFFE);
      chk("t5_pc", 32'(pc), 32'h0010);
      branch(4'h0, 16'h0010);
      branch(4'h1, 16'h000E);

      // BNR mm=1 imm=-2 from pc 0x000F
      fetch_now(32'h7100_FFFE);
      chk("t6_pc", 32'(pc), 32'h000F);
      branch(4'h1, 16'h000F);
      branch(4'h0, 16'h000D);

      // BNE mm=3 imm=0x0123
      fetch_now(32'h6300_0123);
      chk("t7_pc", 32'(pc), 32'h000E);
      branch(4'h4, 16'h0123);

      // pc wrap: jump to 0xFFFF then fetch
      fetch_now(32'h4000_FFFF);
      branch(4'h0, 16'hFFFF);
      fetch_now(32'h4000_0040);
      chk("t8_wrap", 32'(pc), 32'h0000);

      // Simultaneous br_req (BRA 0x0040) and fetch_req
      br_req    = 1'b1;
      fetch_req = 1'b1;
      tick();
      br_req    = 1'b0;
      fetch_req = 1'b0;
      $display("[TB] branch+fetch imem_addr=0x%04h req=%0b", bus.imem_addr, bus.imem_req);
      chk("t9_req",  32'(bus.imem_req),  32'd1);
      chk("t9_addr", 32'(bus.imem_addr), 32'h0040);
      bus.imem_ack  = 1'b1;
      bus.imem_data = 32'h0000_0000;
      tick();
      bus.imem_ack = 1'b0;
      chk("t9_valid", 32'(ir_valid), 32'd1);
      chk("t9_pc",    32'(pc),       32'h0041);
      tick();

      // Ack outside REQ is ignored
      bus.imem_ack  = 1'b1;
      bus.imem_data = 32'hF000_0000;
      tick();
      bus.imem_ack = 1'b0;
      chk("t10_busy",   32'(busy),   32'd0);
      chk("t10_opcode", 32'(opcode), 32'd0);
      chk("t10_halted", 32'(halted), 32'd0);
      chk("t10_pc",     32'(pc),     32'h0041);

      // HLT latch, then fetch_req ignored
      fetch_now(32'hF000_0000);
      chk("t11_halted", 32'(halted), 32'd1);
      chk("t11_opcode", 32'(opcode), 32'd15);
      chk("t11_pc",     32'(pc),     32'h0042);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      $display("[TB] fetch while halted req=%0b busy=%0b", bus.imem_req, busy);
      chk("t11_no_req",  32'(bus.imem_req), 32'd0);
      chk("t11_no_busy", 32'(busy),         32'd0);

      // Reset clears halted
      rst_f = 1'b1;
      tick();
      rst_f = 1'b0;
      chk("t12_halted", 32'(halted), 32'd0);
      chk("t12_pc",     32'(pc),     32'd0);

      // Reset asserted mid-fetch, with ack during and right after reset
      fetch_now(32'h1000_0000);
      chk("t13_pc_pre", 32'(pc), 32'd1);
      fetch_req = 1'b1;
      tick();
      fetch_req = 1'b0;
      chk("t13_in_req", 32'(bus.imem_req), 32'd1);
      rst_f         = 1'b1;
      bus.imem_ack  = 1'b1;
      bus.imem_data = 32'h1234_5678;
      tick();
      rst_f = 1'b0;
      $display("[TB] reset mid-fetch pc=0x%04h req=%0b busy=%0b", pc, bus.imem_req, busy);
      chk("t13_pc",     32'(pc),           32'd0);
      chk("t13_req",    32'(bus.imem_req), 32'd0);
      chk("t13_busy",   32'(busy),         32'd0);
      chk("t13_opcode", 32'(opcode),       32'd0);
      tick();
      bus.imem_ack = 1'b0;
      chk("t13_ack_ign_valid", 32'(ir_valid), 32'd0);
      chk("t13_ack_ign_pc",    32'(pc),       32'd0);
      chk("t13_ack_ign_imm",   32'(imm),      32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
